// File: rtl/partition_stats.sv
// Partition statistics for one pass of the median search: classifies a pixel
// stream against a pivot, counts each class, tracks lower/larger extrema and
// latches the per-iteration sample values for the next-pivot stage.
module partition_stats #(
   parameter logic [10:0] MEDIAN_POS    = 11'd512,
   parameter logic [10:0] BUFF_SIZE     = 11'd1024,
   parameter int          BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [7:0]               in_pivot,
   input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
   input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
   input  logic [7:0]               in_second_median,
   input  logic [7:0]               s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [BUFF_SIZE_BIT-1:0] lower_size,
   output logic [BUFF_SIZE_BIT-1:0] equal_size,
   output logic [BUFF_SIZE_BIT-1:0] larger_size,
   output logic [8:0]               max_lower,
   output logic [8:0]               min_lower,
   output logic [8:0]               max_larger,
   output logic [8:0]               min_larger,
   output logic [8:0]               pivot_samp,
   output logic [BUFF_SIZE_BIT-1:0] buff_size_samp,
   output logic [BUFF_SIZE_BIT-1:0] median_pos_samp,
   output logic [8:0]               second_median_samp,
   output logic                     up_next,
   output logic                     busy
);

   localparam logic [BUFF_SIZE_BIT-1:0] SIZE_MAX = BUFF_SIZE_BIT'(BUFF_SIZE);
   localparam logic [BUFF_SIZE_BIT-1:0] SIZE_ONE = BUFF_SIZE_BIT'(1);
   localparam logic [BUFF_SIZE_BIT-1:0] SIZE_ZERO = '0;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                   state_q, state_d;
   logic [7:0]               pivot_q, pivot_d;
   logic [7:0]               second_q, second_d;
   logic [BUFF_SIZE_BIT-1:0] bsize_q, bsize_d;
   logic [BUFF_SIZE_BIT-1:0] mpos_q, mpos_d;
   logic [BUFF_SIZE_BIT-1:0] cnt_q, cnt_d;
   logic [BUFF_SIZE_BIT-1:0] lower_q, lower_d;
   logic [BUFF_SIZE_BIT-1:0] equal_q, equal_d;
   logic [BUFF_SIZE_BIT-1:0] larger_q, larger_d;
   logic [7:0]               maxl_q, maxl_d;
   logic [7:0]               minl_q, minl_d;
   logic [7:0]               maxg_q, maxg_d;
   logic [7:0]               ming_q, ming_d;

   logic [BUFF_SIZE_BIT-1:0] clamp_size;
   logic [BUFF_SIZE_BIT-1:0] cnt_inc;
   logic                     start_ok;
   logic                     hs;
   logic                     last_px;

   // Oversized requests are clamped so counts can never wrap.
   assign clamp_size = (in_buff_size > SIZE_MAX) ? SIZE_MAX : in_buff_size;
   assign start_ok   = start && (state_q == IDLE);
   assign hs         = s_valid && s_ready;
   assign cnt_inc    = cnt_q + SIZE_ONE;
   assign last_px    = hs && (cnt_inc == bsize_q);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: an empty pass skips RUN; the last handshake ends RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = (clamp_size == SIZE_ZERO) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_px) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      s_ready = (state_q == RUN);
      up_next = (state_q == DONE);
      busy    = (state_q != IDLE);
   end

   // Datapath next values: latch on accepted start, accumulate on handshake
   always_comb begin
      pivot_d  = pivot_q;
      second_d = second_q;
      bsize_d  = bsize_q;
      mpos_d   = mpos_q;
      cnt_d    = cnt_q;
      lower_d  = lower_q;
      equal_d  = equal_q;
      larger_d = larger_q;
      maxl_d   = maxl_q;
      minl_d   = minl_q;
      maxg_d   = maxg_q;
      ming_d   = ming_q;
      if (start_ok) begin
         pivot_d  = in_pivot;
         second_d = in_second_median;
         bsize_d  = clamp_size;
         mpos_d   = in_median_pos;
         cnt_d    = SIZE_ZERO;
         lower_d  = SIZE_ZERO;
         equal_d  = SIZE_ZERO;
         larger_d = SIZE_ZERO;
         maxl_d   = 8'd0;
         minl_d   = 8'd255;
         maxg_d   = 8'd0;
         ming_d   = 8'd255;
      end else if (hs) begin
         cnt_d = cnt_inc;
         if (s_data < pivot_q) begin
            lower_d = lower_q + SIZE_ONE;
            // Both compares see the same pixel, so a lone member sets min and max.
            if (maxl_q < s_data) maxl_d = s_data;
            if (minl_q > s_data) minl_d = s_data;
         end else if (s_data == pivot_q) begin
            equal_d = equal_q + SIZE_ONE;
         end else begin
            larger_d = larger_q + SIZE_ONE;
            if (maxg_q < s_data) maxg_d = s_data;
            if (ming_q > s_data) ming_d = s_data;
         end
      end
   end

   // Datapath registers; reset values match an unstarted pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pivot_q  <= 8'd127;
         second_q <= 8'd127;
         bsize_q  <= SIZE_MAX;
         mpos_q   <= BUFF_SIZE_BIT'(MEDIAN_POS);
         cnt_q    <= SIZE_ZERO;
         lower_q  <= SIZE_ZERO;
         equal_q  <= SIZE_ZERO;
         larger_q <= SIZE_ZERO;
         maxl_q   <= 8'd0;
         minl_q   <= 8'd255;
         maxg_q   <= 8'd0;
         ming_q   <= 8'd255;
      end else begin
         pivot_q  <= pivot_d;
         second_q <= second_d;
         bsize_q  <= bsize_d;
         mpos_q   <= mpos_d;
         cnt_q    <= cnt_d;
         lower_q  <= lower_d;
         equal_q  <= equal_d;
         larger_q <= larger_d;
         maxl_q   <= maxl_d;
         minl_q   <= minl_d;
         maxg_q   <= maxg_d;
         ming_q   <= ming_d;
      end
   end

   assign lower_size         = lower_q;
   assign equal_size         = equal_q;
   assign larger_size        = larger_q;
   assign max_lower          = {1'b0, maxl_q};
   assign min_lower          = {1'b0, minl_q};
   assign max_larger         = {1'b0, maxg_q};
   assign min_larger         = {1'b0, ming_q};
   assign pivot_samp         = {1'b0, pivot_q};
   assign second_median_samp = {1'b0, second_q};
   assign buff_size_samp     = bsize_q;
   assign median_pos_samp    = mpos_q;

endmodule

// File: tb/tb_partition_stats.sv
// Self-checking bench for partition_stats: directed scenarios plus random
// passes, each compared against a list-based reference computation.
module tb_partition_stats;

   localparam int BSB = 11;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [7:0]     in_pivot = 8'd0;
   logic [BSB-1:0] in_buff_size = '0;
   logic [BSB-1:0] in_median_pos = '0;
   logic [7:0]     in_second_median = 8'd0;
   logic [7:0]     s_data = 8'd0;
   logic           s_valid = 1'b0;
   logic           s_ready;
   logic [BSB-1:0] lower_size, equal_size, larger_size;
   logic [8:0]     max_lower, min_lower, max_larger, min_larger;
   logic [8:0]     pivot_samp;
   logic [BSB-1:0] buff_size_samp, median_pos_samp;
   logic [8:0]     second_median_samp;
   logic           up_next, busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] pix [0:2047];
   int e_lo, e_eq, e_gt, e_maxl, e_minl, e_maxg, e_ming;

   partition_stats dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_pivot(in_pivot),
      .in_buff_size(in_buff_size), .in_median_pos(in_median_pos),
      .in_second_median(in_second_median), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .lower_size(lower_size), .equal_size(equal_size),
      .larger_size(larger_size), .max_lower(max_lower), .min_lower(min_lower),
      .max_larger(max_larger), .min_larger(min_larger), .pivot_samp(pivot_samp),
      .buff_size_samp(buff_size_samp), .median_pos_samp(median_pos_samp),
      .second_median_samp(second_median_samp), .up_next(up_next), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [68:0] dut_stats();
      return {lower_size, equal_size, larger_size, max_lower, min_lower, max_larger, min_larger};
   endfunction

   function automatic logic [68:0] exp_stats();
      return {BSB'(e_lo), BSB'(e_eq), BSB'(e_gt), 9'(e_maxl), 9'(e_minl), 9'(e_maxg), 9'(e_ming)};
   endfunction

   // Reference: classify the first n pixels of the list with plain arithmetic.
   task automatic model(input int pv, input int n);
      e_lo = 0; e_eq = 0; e_gt = 0;
      e_maxl = 0; e_minl = 255; e_maxg = 0; e_ming = 255;
      for (int i = 0; i < n; i++) begin
         int p;
         p = int'(pix[i]);
         if (p < pv) begin
            e_lo++;
            if (p > e_maxl) e_maxl = p;
            if (p < e_minl) e_minl = p;
         end else if (p == pv) begin
            e_eq++;
         end else begin
            e_gt++;
            if (p > e_maxg) e_maxg = p;
            if (p < e_ming) e_ming = p;
         end
      end
   endtask

   // Runs one pass; gap_mode 0 continuous, 1 alternate, 2 random valid.
   task automatic run_pass(input int pv, input int sz, input int mp, input int sm,
                           input int gap_mode, input bit inject,
                           output int hs, output int lat, output bit saw_ready,
                           output bit ready_drop);
      bit v;
      hs = 0; lat = 0; saw_ready = 0; ready_drop = 0;
      @(negedge clk);
      start = 1'b1;
      in_pivot = 8'(pv);
      in_buff_size = BSB'(sz);
      in_median_pos = BSB'(mp);
      in_second_median = 8'(sm);
      s_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!up_next && lat < 3000) begin
         if (gap_mode == 0) v = 1'b1;
         else if (gap_mode == 1) v = (lat % 2) == 0;
         else v = $urandom_range(0, 1) == 1;
         if (inject && lat == 2) begin
            start = 1'b1;
            in_pivot = ~8'(pv);
            in_buff_size = BSB'(5);
            in_median_pos = BSB'(3);
            in_second_median = ~8'(sm);
         end else begin
            start = 1'b0;
         end
         s_valid = v;
         s_data = (hs < 2048) ? pix[hs] : 8'd0;
         if (s_ready) saw_ready = 1'b1;
         else ready_drop = 1'b1;
         if (v && s_ready) hs++;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (!up_next) begin
         checks++; errors++;
         $display("FAIL timeout: up_next not seen within %0d cycles", lat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({s_ready, up_next, busy} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 000", {s_ready, up_next, busy});
      end
      checks++;
      e_lo = 0; e_eq = 0; e_gt = 0; e_maxl = 0; e_minl = 255; e_maxg = 0; e_ming = 255;
      if (dut_stats() !== exp_stats()) begin
         errors++; $display("FAIL reset_stats: got %h want %h", dut_stats(), exp_stats());
      end
      checks++;
      if ({pivot_samp, second_median_samp, buff_size_samp, median_pos_samp} !==
          {9'd127, 9'd127, 11'd1024, 11'd512}) begin
         errors++; $display("FAIL reset_samp: got %0d %0d %0d %0d want 127 127 1024 512",
                            pivot_samp, second_median_samp, buff_size_samp, median_pos_samp);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int hs, lat; bit sr, rd;
      pix[0] = 8'd50; pix[1] = 8'd100; pix[2] = 8'd200; pix[3] = 8'd100;
      run_pass(100, 4, 2, 77, 0, 1'b0, hs, lat, sr, rd);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
      e_lo = 1; e_eq = 2; e_gt = 1; e_maxl = 50; e_minl = 50; e_maxg = 200; e_ming = 200;
      checks++;
      if (dut_stats() !== exp_stats()) begin
         errors++; $display("FAIL basic_stats: got %h want %h", dut_stats(), exp_stats());
      end
      checks++;
      if ({pivot_samp, buff_size_samp, median_pos_samp, second_median_samp} !==
          {9'd100, 11'd4, 11'd2, 9'd77}) begin
         errors++; $display("FAIL basic_samp: got %0d %0d %0d %0d want 100 4 2 77",
                            pivot_samp, buff_size_samp, median_pos_samp, second_median_samp);
      end
      checks++;
      if ({s_ready, busy} !== 2'b01) begin
         errors++; $display("FAIL basic_done_ctrl: got %b want 01", {s_ready, busy});
      end
      s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({up_next, busy, s_ready} !== 3'b000 || dut_stats() !== exp_stats()) begin
         errors++; $display("FAIL basic_hold: ctrl %b stats %h want 000 %h",
                            {up_next, busy, s_ready}, dut_stats(), exp_stats());
      end
   endtask

   task automatic test_gaps();
      int hs, lat; bit sr, rd;
      pix[0] = 8'd20; pix[1] = 8'd30; pix[2] = 8'd40;
      run_pass(10, 3, 1, 5, 1, 1'b0, hs, lat, sr, rd);
      s_valid = 1'b0;
      e_lo = 0; e_eq = 0; e_gt = 3; e_maxl = 0; e_minl = 255; e_maxg = 40; e_ming = 20;
      checks++;
      if (dut_stats() !== exp_stats()) begin
         errors++; $display("FAIL gaps_stats: got %h want %h", dut_stats(), exp_stats());
      end
      checks++;
      if (rd !== 1'b0 || hs !== 3) begin
         errors++; $display("FAIL gaps_ready: drop %0d handshakes %0d want 0 3", rd, hs);
      end
   endtask

   task automatic test_zero();
      int hs, lat; bit sr, rd;
      run_pass(60, 0, 0, 9, 0, 1'b0, hs, lat, sr, rd);
      s_valid = 1'b0;
      checks++;
      if (lat !== 1 || sr !== 1'b0 || hs !== 0) begin
         errors++; $display("FAIL zero_size: lat %0d ready %0d hs %0d want 1 0 0", lat, sr, hs);
      end
      model(60, 0);
      checks++;
      if (dut_stats() !== exp_stats() || buff_size_samp !== 11'd0) begin
         errors++; $display("FAIL zero_stats: got %h size %0d want %h 0",
                            dut_stats(), buff_size_samp, exp_stats());
      end
   endtask

   task automatic test_clamp();
      int hs, lat; bit sr, rd;
      for (int i = 0; i < 2048; i++) pix[i] = 8'($urandom);
      run_pass(128, 2047, 600, 1, 0, 1'b0, hs, lat, sr, rd);
      s_valid = 1'b0;
      model(128, 1024);
      checks++;
      if (hs !== 1024 || buff_size_samp !== 11'd1024) begin
         errors++; $display("FAIL clamp_count: hs %0d size %0d want 1024 1024", hs, buff_size_samp);
      end
      checks++;
      if (32'(lower_size) + 32'(equal_size) + 32'(larger_size) !== 1024 ||
          dut_stats() !== exp_stats()) begin
         errors++; $display("FAIL clamp_stats: got %h want %h", dut_stats(), exp_stats());
      end
   endtask

   task automatic test_start_ignored();
      int hs, lat; bit sr, rd;
      for (int i = 0; i < 12; i++) pix[i] = 8'($urandom_range(40, 220));
      run_pass(130, 12, 6, 33, 2, 1'b1, hs, lat, sr, rd);
      s_valid = 1'b0;
      model(130, 12);
      checks++;
      if ({pivot_samp, buff_size_samp, median_pos_samp, second_median_samp} !==
          {9'd130, 11'd12, 11'd6, 9'd33} || hs !== 12) begin
         errors++; $display("FAIL ignore_start_samp: got %0d %0d %0d %0d hs %0d want 130 12 6 33 12",
                            pivot_samp, buff_size_samp, median_pos_samp, second_median_samp, hs);
      end
      checks++;
      if (dut_stats() !== exp_stats()) begin
         errors++; $display("FAIL ignore_start_stats: got %h want %h", dut_stats(), exp_stats());
      end
   endtask

   task automatic test_reset_midpass();
      int hs, lat; bit sr, rd; bit seen;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1; in_pivot = 8'd90; in_buff_size = 11'd10;
      in_median_pos = 11'd4; in_second_median = 8'd44;
      @(negedge clk);
      start = 1'b0; s_valid = 1'b1; s_data = 8'd10;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_ready, busy, up_next} !== 3'b000 || lower_size !== 11'd0 || pivot_samp !== 9'd127) begin
         errors++; $display("FAIL midreset_values: ctrl %b lower %0d pivot %0d want 000 0 127",
                            {s_ready, busy, up_next}, lower_size, pivot_samp);
      end
      repeat (4) begin
         @(negedge clk);
         if (up_next) seen = 1'b1;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (up_next) seen = 1'b1;
      end
      s_valid = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL midreset_up_next: got %0d want 0", seen);
      end
      for (int i = 0; i < 6; i++) pix[i] = 8'($urandom);
      run_pass(int'(pix[2]), 6, 3, 8, 0, 1'b0, hs, lat, sr, rd);
      s_valid = 1'b0;
      model(int'(pix[2]), 6);
      checks++;
      if (dut_stats() !== exp_stats() || lat !== 7) begin
         errors++; $display("FAIL midreset_fresh: got %h lat %0d want %h 7", dut_stats(), lat, exp_stats());
      end
   endtask

   task automatic test_random();
      int hs, lat, pv, sz; bit sr, rd;
      for (int t = 0; t < 10; t++) begin
         pv = int'($urandom_range(0, 255));
         sz = int'($urandom_range(1, 40));
         for (int i = 0; i < sz; i++) pix[i] = (t % 3 == 0) ? 8'(pv) + 8'($urandom_range(0, 2)) - 8'd1
                                                           : 8'($urandom);
         run_pass(pv, sz, sz / 2, t, 2, 1'b0, hs, lat, sr, rd);
         s_valid = 1'b0;
         model(pv, sz);
         checks++;
         if (dut_stats() !== exp_stats() || hs !== sz ||
             32'(lower_size) + 32'(equal_size) + 32'(larger_size) !== 32'(buff_size_samp)) begin
            errors++; $display("FAIL random_%0d: got %h hs %0d want %h hs %0d",
                               t, dut_stats(), hs, exp_stats(), sz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_zero();
      test_clamp();
      test_start_ignored();
      test_reset_midpass();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
